// File: rtl/booth_mac_accumulator.sv
// Accumulates a programmed number (len) of signed Booth-multiplier products into one signed sum.
// Latency: a start accepted at edge N takes len products from edge N+1 on; the sum is valid right after the last product edge.
// Backpressure: the finished sum holds in DONE until acc_ready; products seen in IDLE or DONE are dropped.
// Build option: define SATURATE_EN to clamp on signed overflow. Without it the sum wraps modulo 2^AW.
module booth_mac_accumulator #(
  parameter int PW    = 16,
  parameter int AW    = 18,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             prod_valid,
  input  logic [PW-1:0]    prod,
  input  logic             prod_carry,
  input  logic             acc_ready,
  output logic             busy,
  output logic [AW-1:0]    acc_out,
  output logic             acc_valid,
  output logic             ovf,
  output logic             carry_seen
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW:0]      sum_wide;
  logic             sum_ovf;
  logic [AW-1:0]    acc_next;
  logic             start_ok;

  // A start with len=0 is not a block at all, so it is never accepted.
  assign start_ok = start && (len != '0);

  // Add one sign-extended product with a guard bit, so that overflow shows as a top-two-bit disagreement.
  always_comb begin
    sum_wide = {acc_out[AW-1], acc_out} + {{(AW+1-PW){prod[PW-1]}}, prod};
    sum_ovf  = sum_wide[AW] ^ sum_wide[AW-1];
    acc_next = sum_wide[AW-1:0];
`ifdef SATURATE_EN
    // The guard bit carries the sign of the true sum, so it selects the clamp direction.
    if (sum_ovf) begin
      acc_next = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`endif
  end

  // Block FSM. All outputs are registered here, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      ovf        <= 1'b0;
      carry_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= ACCUM;
            cnt        <= len;
            busy       <= 1'b1;
            acc_out    <= '0;
            ovf        <= 1'b0;
            carry_seen <= 1'b0;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out    <= acc_next;
            ovf        <= ovf | sum_ovf;
            carry_seen <= carry_seen | prod_carry;
            cnt        <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            // A start in the release cycle chains straight into the next block with no idle cycle.
            if (start_ok) begin
              state      <= ACCUM;
              cnt        <= len;
              acc_out    <= '0;
              ovf        <= 1'b0;
              carry_seen <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: reset, basic, negative, overflow, handshake, carry/len=0.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_booth_mac_accumulator;
  localparam int PW = 16;
  localparam int AW = 18;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             prod_valid;
  logic [PW-1:0]    prod;
  logic             prod_carry;
  logic             acc_ready;
  logic             busy;
  logic [AW-1:0]    acc_out;
  logic             acc_valid;
  logic             ovf;
  logic             carry_seen;

  int checks = 0;
  int failures = 0;

  booth_mac_accumulator #(.PW(PW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_carry(prod_carry),
    .acc_ready(acc_ready), .busy(busy), .acc_out(acc_out),
    .acc_valid(acc_valid), .ovf(ovf), .carry_seen(carry_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
    prod_carry = 1'b0; acc_ready = 1'b0;
  endtask

  // Issue a start; it is accepted at the next edge.
  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1; len = l;
    cyc();
    start = 1'b0; len = '0;
  endtask

  // Present one product for one edge.
  task automatic do_prod(input logic [PW-1:0] p, input logic c);
    prod_valid = 1'b1; prod = p; prod_carry = c;
    cyc();
    prod_valid = 1'b0; prod = '0; prod_carry = 1'b0;
  endtask

  task automatic release_done();
    acc_ready = 1'b1;
    cyc();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if ({busy, acc_out, acc_valid, ovf, carry_seen} !== '0) begin
      failures++;
      $display("FAIL reset_values: got busy=%b acc=%h vld=%b ovf=%b cs=%b want all 0",
               busy, acc_out, acc_valid, ovf, carry_seen);
    end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    // Assert reset in the middle of a 4-product block.
    do_start(4'd4);
    do_prod(16'h1234, 1'b1);
    do_prod(16'h0100, 1'b0);
    checks++;
    if (acc_out !== 18'h01334 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_partial_sum: got acc=%h busy=%b want acc=01334 busy=1", acc_out, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, acc_out, acc_valid, ovf, carry_seen} !== '0) begin
      failures++;
      $display("FAIL reset_midblock: got busy=%b acc=%h vld=%b ovf=%b cs=%b want all 0",
               busy, acc_out, acc_valid, ovf, carry_seen);
    end
    cyc();
    rst = 1'b1;
    cyc();
    prod_valid = 1'b1; prod = 16'h0777;
    cyc(); cyc(); cyc();
    prod_valid = 1'b0; prod = '0;
    checks++;
    if (busy !== 1'b0 || acc_out !== '0 || acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_ignores_prod: got busy=%b acc=%h vld=%b want 0 0 0", busy, acc_out, acc_valid);
    end
  endtask

  task automatic test_basic();
    do_start(4'd3);
    checks++;
    if (busy !== 1'b1 || acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after_start: got busy=%b vld=%b want 1 0", busy, acc_valid);
    end
    do_prod(16'h4000, 1'b0);
    cyc();
    do_prod(16'h4000, 1'b0);
    cyc(); cyc();
    checks++;
    if (acc_valid !== 1'b0 || acc_out !== 18'h08000) begin
      failures++;
      $display("FAIL basic_two_of_three: got vld=%b acc=%h want 0 08000", acc_valid, acc_out);
    end
    do_prod(16'h4000, 1'b0);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 18'h0C000 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got vld=%b acc=%h ovf=%b want 1 0C000 0", acc_valid, acc_out, ovf);
    end
    release_done();
    checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_release: got vld=%b busy=%b want 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_negative();
    do_start(4'd2);
    do_prod(16'hC000, 1'b0);
    do_prod(16'h0100, 1'b0);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 18'h3C100 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL negative_sum: got vld=%b acc=%h ovf=%b want 1 3C100 0", acc_valid, acc_out, ovf);
    end
    release_done();
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_acc;
`ifdef SATURATE_EN
    exp_acc = 18'h1FFFF;
`else
    exp_acc = 18'h27FFB;
`endif
    do_start(4'd5);
    for (int i = 0; i < 4; i++) do_prod(16'h7FFF, 1'b0);
    checks++;
    if (ovf !== 1'b0 || acc_out !== 18'h1FFFC) begin
      failures++;
      $display("FAIL overflow_before: got acc=%h ovf=%b want 1FFFC 0", acc_out, ovf);
    end
    do_prod(16'h7FFF, 1'b0);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== exp_acc || ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_result: got vld=%b acc=%h ovf=%b want 1 %h 1", acc_valid, acc_out, ovf, exp_acc);
    end
    release_done();
  endtask

  task automatic test_handshake();
    int bad;
    bad = 0;
    do_start(4'd1);
    do_prod(16'h0010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      prod_valid = i[0]; prod = 16'h0100; start = i[1]; len = 4'd3;
      cyc();
      if (acc_out !== 18'h00010 || acc_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL handshake_hold: %0d of 10 cycles unstable, last acc=%h vld=%b want 00010 1", bad, acc_out, acc_valid);
    end
    acc_ready = 1'b1; start = 1'b1; len = 4'd1;
    cyc();
    idle_inputs();
    checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b1 || acc_out !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL handshake_chain: got vld=%b busy=%b acc=%h ovf=%b want 0 1 0 0", acc_valid, busy, acc_out, ovf);
    end
    do_prod(16'hFFFB, 1'b0);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 18'h3FFFB) begin
      failures++;
      $display("FAIL handshake_next_block: got vld=%b acc=%h want 1 3FFFB", acc_valid, acc_out);
    end
    release_done();
  endtask

  task automatic test_carry();
    do_start(4'd0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_ignored: got busy=%b want 0", busy);
    end
    do_start(4'd2);
    do_prod(16'h0001, 1'b0);
    checks++;
    if (carry_seen !== 1'b0) begin
      failures++;
      $display("FAIL carry_first: got cs=%b want 0", carry_seen);
    end
    do_prod(16'h0002, 1'b1);
    checks++;
    if (carry_seen !== 1'b1 || acc_out !== 18'h00003 || acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL carry_seen: got cs=%b acc=%h vld=%b want 1 00003 1", carry_seen, acc_out, acc_valid);
    end
    release_done();
    do_start(4'd1);
    checks++;
    if (carry_seen !== 1'b0 || acc_out !== '0) begin
      failures++;
      $display("FAIL carry_cleared: got cs=%b acc=%h want 0 0", carry_seen, acc_out);
    end
    do_prod(16'h0004, 1'b0);
    release_done();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_handshake();
    test_carry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
